// File: rtl/autobaud_detector.sv
// rtl/autobaud_detector.sv - measures serial bit period by timing a 0x55 sync character
// Optional AUTOBAUD_TOLERANCE_CHECK_EN: reject edge intervals deviating > 1/4 from the first.

module autobaud_detector #(
    parameter int CLOCK_RATE = 50000000,
    parameter int MIN_BAUD   = 1200,
    parameter int CNT_WIDTH  = $clog2(8 * (CLOCK_RATE / MIN_BAUD) + 1)
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_rx,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic                 o_error,
    output logic [CNT_WIDTH-1:0] o_bit_period,
    output logic [CNT_WIDTH-1:0] o_half_period
);

    localparam int MAX_PERIOD = CLOCK_RATE / MIN_BAUD;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [3:0]           idle_cnt_q, idle_cnt_d;
    logic [3:0]           edge_cnt_q, edge_cnt_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] interval_q, interval_d;
    logic [CNT_WIDTH-1:0] bit_period_q, bit_period_d;
    logic [CNT_WIDTH-1:0] half_period_q, half_period_d;
    logic [CNT_WIDTH-1:0] total_inc, interval_inc;
    logic                 rx_edge, rx_fall, tol_fail;

    assign rx_edge      = rx_sync_q ^ rx_prev_q;
    assign rx_fall      = rx_edge & ~rx_sync_q;
    assign total_inc    = total_q + 1'b1;
    assign interval_inc = interval_q + 1'b1;

`ifdef AUTOBAUD_TOLERANCE_CHECK_EN
    logic [CNT_WIDTH-1:0] ref_q, ref_d;
    logic [CNT_WIDTH-1:0] diff;

    always_comb begin
        diff     = (interval_inc > ref_q) ? (interval_inc - ref_q) : (ref_q - interval_inc);
        tol_fail = (edge_cnt_q != 4'd0) && (diff > (ref_q >> 2));
    end

    always_comb begin
        ref_d = ref_q;
        if (state_q == S_MEASURE && rx_edge && edge_cnt_q == 4'd0) begin
            ref_d = interval_inc;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ref_q <= '0;
        end else begin
            ref_q <= ref_d;
        end
    end
`else
    assign tol_fail = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        edge_cnt_d    = edge_cnt_q;
        total_d       = total_q;
        interval_d    = interval_q;
        bit_period_d  = bit_period_q;
        half_period_d = half_period_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_WAIT_IDLE;
                    idle_cnt_d = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (!rx_sync_q) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == 4'd15) begin
                    state_d = S_WAIT_START;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            S_WAIT_START: begin
                if (rx_fall) begin
                    state_d    = S_MEASURE;
                    total_d    = '0;
                    interval_d = '0;
                    edge_cnt_d = '0;
                end
            end
            S_MEASURE: begin
                total_d    = total_inc;
                interval_d = interval_inc;
                // An edge landing exactly on MAX_PERIOD is a valid slowest-baud bit.
                if (rx_edge) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    interval_d = '0;
                    if (tol_fail) begin
                        state_d = S_ERROR;
                    end else if (edge_cnt_q == 4'd7) begin
                        state_d       = S_DONE;
                        bit_period_d  = total_inc >> 3;
                        half_period_d = total_inc >> 4;
                    end
                end else if (interval_inc >= MAX_CNT) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_prev_q     <= 1'b1;
            idle_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            total_q       <= '0;
            interval_q    <= '0;
            bit_period_q  <= '0;
            half_period_q <= '0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= i_rx;
            rx_sync_q     <= rx_meta_q;
            rx_prev_q     <= rx_sync_q;
            idle_cnt_q    <= idle_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            total_q       <= total_d;
            interval_q    <= interval_d;
            bit_period_q  <= bit_period_d;
            half_period_q <= half_period_d;
        end
    end

    assign o_busy        = (state_q == S_WAIT_IDLE) || (state_q == S_WAIT_START) ||
                           (state_q == S_MEASURE);
    assign o_valid       = (state_q == S_DONE);
    assign o_error       = (state_q == S_ERROR);
    assign o_bit_period  = bit_period_q;
    assign o_half_period = half_period_q;

endmodule

// File: tb/tb_autobaud_detector.sv
// tb/tb_autobaud_detector.sv - scoreboard bench for autobaud_detector
// Clock rate scaled to 5 MHz so the 1200-baud case (4166 cycles/bit) stays short.

module tb_autobaud_detector;

    localparam int CLK_RATE = 5000000;
    localparam int MINBAUD  = 1200;
    localparam int CW       = $clog2(8 * (CLK_RATE / MINBAUD) + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          start = 1'b0;
    logic          busy, valid, error;
    logic [CW-1:0] bit_period, half_period;

    typedef struct {
        bit is_err;
        int period;
        int half;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   resp_cnt = 0;

    autobaud_detector #(
        .CLOCK_RATE(CLK_RATE),
        .MIN_BAUD  (MINBAUD),
        .CNT_WIDTH (CW)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_rx         (rx),
        .i_start      (start),
        .o_busy       (busy),
        .o_valid      (valid),
        .o_error      (error),
        .o_bit_period (bit_period),
        .o_half_period(half_period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (valid || error)) begin
            exp_t e;
            resp_cnt = resp_cnt + 1;
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_response: valid=%0d error=%0d, expected none", valid, error);
            end else begin
                e = exp_q.pop_front();
                chk("resp_kind_error", int'(error), int'(e.is_err));
                chk("resp_kind_valid", int'(valid), int'(!e.is_err));
                chk("bit_period", int'(bit_period), e.period);
                chk("half_period", int'(half_period), e.half);
                chk("busy_at_resp", int'(busy), 0);
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm();
        start = 1'b1;
        wait_n(1);
        start = 1'b0;
    endtask

    task automatic push(input bit is_err, input int p, input int h);
        exp_t e;
        e.is_err = is_err;
        e.period = p;
        e.half   = h;
        exp_q.push_back(e);
    endtask

    task automatic send_char(input logic [7:0] b, input int t);
        logic [7:0] v;
        v  = b;
        rx = 1'b0;
        wait_n(t);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            wait_n(t);
        end
        rx = 1'b1;
        wait_n(t);
    endtask

    task automatic wait_resp(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (resp_cnt < target && n < budget) begin
            wait_n(1);
            n++;
        end
        chk(name, resp_cnt, target);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while the line toggles
        for (int i = 0; i < 20; i++) begin
            rx = i[0];
            wait_n(1);
        end
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_bit_period", int'(bit_period), 0);
        chk("rst_half_period", int'(half_period), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx = i[1];
            wait_n(1);
        end
        rx = 1'b1;
        chk("idle_no_arm_busy", int'(busy), 0);
        wait_n(10);

        // Clean 0x55 at 434 cycles/bit
        arm();
        chk("armed_busy", int'(busy), 1);
        wait_n(30);
        push(1'b0, 434, 217);
        send_char(8'h55, 434);
        wait_resp("resp_434", 1, 200);

        // Slowest baud, then timeout with line stuck low
        arm();
        wait_n(30);
        push(1'b0, 4166, 2083);
        send_char(8'h55, 4166);
        wait_resp("resp_slow", 2, 500);
        arm();
        wait_n(30);
        push(1'b1, 4166, 2083);
        rx = 1'b0;
        wait_resp("resp_timeout", 3, 4166 + 200);
        rx = 1'b1;
        wait_n(30);

        // Three back-to-back 0x0F frames at 434 cycles/bit
        arm();
        wait_n(30);
`ifdef AUTOBAUD_TOLERANCE_CHECK_EN
        push(1'b1, 4166, 2083);
`else
        push(1'b0, 1085, 542);
`endif
        send_char(8'h0F, 434);
        send_char(8'h0F, 434);
        send_char(8'h0F, 434);
        wait_resp("resp_0f", 4, 200);
        wait_n(30);

        // Low glitch right after arm and a second start pulse mid-measurement
        arm();
        rx = 1'b0;
        wait_n(10);
        rx = 1'b1;
        wait_n(40);
        push(1'b0, 434, 217);
        fork
            send_char(8'h55, 434);
            begin
                wait_n(3 * 434);
                arm();
            end
        join
        wait_resp("resp_restart_ignored", 5, 200);
        wait_n(30);

        // Reset asserted around edge 5, then a fresh 868 cycles/bit measurement
        arm();
        wait_n(30);
        rx = 1'b0;
        wait_n(434);
        for (int i = 0; i < 5; i++) begin
            rx = ~rx;
            wait_n(434);
        end
        wait_n(10);
        chk("mid_measure_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bit_period", int'(bit_period), 0);
        chk("midrst_half_period", int'(half_period), 0);
        rx = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);
        arm();
        wait_n(30);
        push(1'b0, 868, 434);
        send_char(8'h55, 868);
        wait_resp("resp_868", 6, 200);

        wait_n(100);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("total_responses", resp_cnt, 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/autobaud_detector.md
Name: autobaud_detector

Overview:
- Measures the bit period of an incoming asynchronous serial line by timing a 0x55 sync character (start bit + alternating data bits, LSB first).
- Produces the per-bit cycle count and half-period count in i_clock cycles, so firmware or hardware can program a baud divider or UART.
- Sits on the UART RX pin, beside the UART receiver, under software control (arm / result / error).

Parameters:
- CLOCK_RATE, 50000000, i_clock frequency in Hz.
- MIN_BAUD, 1200, slowest supported baud; sets the timeout MAX_PERIOD = CLOCK_RATE / MIN_BAUD.
- CNT_WIDTH, $clog2(8*MAX_PERIOD+1), derived width of the total-time counter (19 with the defaults).

Ports:
- i_clock  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_rx  input  1  raw serial line, idle high, asynchronous to i_clock
- i_start  input  1  one-cycle arm request; ignored while o_busy=1
- o_busy  output  1  high from accepted i_start until o_valid/o_error
- o_valid  output  1  one-cycle pulse: new measurement available
- o_error  output  1  one-cycle pulse: measurement aborted (timeout or tolerance)
- o_bit_period  output  CNT_WIDTH  measured cycles per bit
- o_half_period  output  CNT_WIDTH  o_bit_period >> 1

Behaviour:
- Reset (async assert, sync deassert to clock edge): all outputs 0, state IDLE, synchroniser flops 1, counters 0.
- i_rx passes through a 2-flop synchroniser; an edge is detected when the synchronised value differs from its 1-cycle-delayed copy. Edge-detect latency from i_rx is 3 cycles. The offset is identical for every edge, so the measurement is unaffected.
- States:
  - IDLE: on i_start, go to WAIT_IDLE with o_busy=1.
  - WAIT_IDLE: line high for 16 consecutive cycles -> WAIT_START. A low resets the 16-cycle count.
  - WAIT_START: falling edge -> MEASURE. Clear the total counter, the interval counter and the edge count (edge_cnt=0); the reference interval is not yet set. No timeout applies in this state.
  - MEASURE:
    - The total counter and the interval counter increment every cycle.
    - On each edge, edge_cnt increments.
    - On the first edge, the interval counter value is latched as ref_interval.
    - On every edge, the interval counter is cleared.
    - When the 8th edge after start arrives (the falling edge at bit time 8), go to DONE.
    - If the interval counter reaches MAX_PERIOD, go to ERROR.
  - DONE (1 cycle):
    - o_bit_period <= total >> 3 (truncating); o_half_period <= total >> 4.
    - o_valid=1, o_busy=0, then IDLE.
  - ERROR (1 cycle): o_error=1, o_busy=0, o_bit_period / o_half_period unchanged, then IDLE.
- o_bit_period / o_half_period hold their last successful value until the next DONE.
- i_start in any non-IDLE state is ignored; there is no abort input, and reset is the only abort.
- Reset mid-measurement: immediate return to IDLE with outputs 0.
- Counter arithmetic is unsigned and cannot overflow: MEASURE exits before total exceeds 8*MAX_PERIOD.

Optional Feature:
- Macro: AUTOBAUD_TOLERANCE_CHECK_EN
- Defined: on edges 2 through 8 of MEASURE, the interval is compared with ref_interval. If |interval - ref_interval| > (ref_interval >> 2), go to ERROR. This rejects non-0x55 characters and glitches.
- Not defined: no comparison is made, ref_interval is not stored, and only the timeout can produce o_error.

Test Plan:
- Reset: hold i_reset_n=0 with i_rx toggling -> o_busy/o_valid/o_error/o_bit_period/o_half_period all 0; release, no activity until i_start.
- Clean 0x55 at 434 cycles/bit (about 115200 baud at 50 MHz) after i_start -> one o_valid pulse, o_bit_period=434, o_half_period=217, o_busy low the same cycle.
- Clean 0x55 at 41666 cycles/bit (1200 baud) -> o_valid with o_bit_period=41666. Then line held low 41666 cycles after start on a fresh arm -> o_error pulse, o_bit_period still 41666.
- With AUTOBAUD_TOLERANCE_CHECK_EN: send 0x0F at 434 cycles/bit -> o_error (4-bit interval vs 434 ref). Without the macro, the same stimulus completes; the bench checks o_valid and records the value.
- i_start pulsed again mid-MEASURE and line low for 10 cycles right after arm -> second start ignored, WAIT_IDLE delays the start-edge search until 16 high cycles, result still 434.
- i_reset_n asserted at edge 5 of a measurement -> outputs 0 immediately; a fresh i_start plus clean 0x55 at 868 cycles/bit -> o_bit_period=868.
